rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer at the consuming end of the result broadcast bus (`ready`/`rob_id`/`value`) driven by the reservation station and the load/store buffer.
- Allocates one entry per decoded instruction and captures both broadcast streams.
- Forwards operands to the decoder and commits in program order: register writes, store release and halt.
- On a branch mispredict it drives the pipeline-wide `clear` and the redirect PC.

Parameters:
- ROB_SIZE, 8, number of entries; must be a power of two.
- ROB_WIDTH, 3, log2(ROB_SIZE); entry id width.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global ready; state holds when low
- dec_ready  in  1  decoder issues one instruction this cycle
- dec_type  in  2  0=reg write, 1=branch, 2=store, 3=halt
- dec_rd  in  5  destination register (type 0 only)
- dec_pred_addr  in  32  predicted next PC (type 1 only)
- dec_val_ready  in  1  result is already known at issue (lui/jal/auipc)
- dec_value  in  32  that result
- rob_full  out  1  no free entry
- rob_tail_id  out  ROB_WIDTH  id the next issue will receive
- rs_ready, rs_rob_id, rs_value  in  1/ROB_WIDTH/32  RS broadcast
- lsb_ready, lsb_rob_id, lsb_value  in  1/ROB_WIDTH/32  LSB broadcast
- query_j_id, query_k_id  in  ROB_WIDTH  operand lookups
- query_j_ready, query_k_ready  out  1  value is available
- query_j_value, query_k_value  out  32  that value
- commit_valid  out  1  register-write commit pulse
- commit_rd  out  5  destination register of the commit
- commit_value  out  32  value written
- commit_rob_id  out  ROB_WIDTH  regfile clears its tag if equal
- store_commit  out  1  pulse; LSB may perform the store
- store_rob_id  out  ROB_WIDTH  id of that store
- clear  out  1  flush pulse to all units
- redirect_pc  out  32  fetch target, valid while clear is high
- halt  out  1  sticky halt

Behaviour:
- Reset (rst_in low, asynchronous): head=tail=count=0 and all entries not busy. Every output is 0; `rob_full`=0 and `rob_tail_id`=0.
- rdy_in low: no state changes. All pulse outputs (commit_valid, store_commit, clear) are 0 after that edge.
- Issue: when `dec_ready` and not `clear`, the entry at tail is written with busy=1, type, rd, pred_addr, ready=`dec_val_ready` and value=`dec_value`; tail increments mod ROB_SIZE. Issue while `rob_full` is a decoder protocol violation; the ROB ignores it.
- Writeback: each busy entry whose id equals `rs_rob_id` (when `rs_ready`) or `lsb_rob_id` (when `lsb_ready`) sets ready=1 and captures the value. Both streams apply in the same cycle to different ids. If both target the same id, LSB wins.
- Query (combinational) checks three sources in this order:
  - entry ready → its stored value;
  - else `rs_ready` with a matching id → `rs_value`;
  - else `lsb_ready` with a matching id → `lsb_value`;
  - else ready=0, value=0.
- Commit: at most one per cycle, only when head is busy and ready and `clear` is low. The entry is freed and head increments.
  - Type 0: next cycle commit_valid=1 with rd/value/id; rd=0 is still pulsed.
  - Type 2: next cycle store_commit=1 with store_rob_id.
  - Type 3: halt=1 permanently; no further commits.
  - Type 1, value == pred_addr: freed silently.
  - Type 1, value != pred_addr (mispredict): at the same edge head=tail=count=0 and all entries are cleared. Next cycle clear=1 for exactly one cycle with redirect_pc=value. An issue in that same cycle is discarded.
- Count: count = count + issue − commit, so a full buffer committing and issuing in the same cycle stays full. `rob_full` = (count == ROB_SIZE), registered from the new count.
- Wrap: head and tail wrap mod ROB_SIZE; with head == tail, count distinguishes full from empty.
- Latency:
  - broadcast → commit eligibility: 1 cycle;
  - commit edge → `commit_valid` / `store_commit` / `clear`: registered, visible the cycle after.

Decomposition:
- Shared package holds ROB_SIZE, ROB_WIDTH and the dec_type codes (TYPE_REG, TYPE_BR, TYPE_ST, TYPE_HALT); the RS, LSB and decoder use the same definitions.
- Sub-module rob_query: combinational bypass lookup, instantiated twice (j, k).

Test Plan:
- Issue reg-write rd=5 as id 0, then rs broadcast id0 value 0x1234 → next cycle commit_valid=1, commit_rd=5, commit_value=0x1234, commit_rob_id=0.
- Issue ids 0,1; lsb writes id1=7 first, rs writes id0=3 two cycles later → commits ordered id0(3) then id1(7), never id1 first.
- Fill 8 entries → rob_full=1 and rob_tail_id=0 (wrapped). Then commit and issue in the same cycle → rob_full stays 1, tail=1.
- Branch with pred 0x100 resolved as 0x200 behind 3 younger entries → clear=1 for one cycle, redirect_pc=0x200, rob_full=0, rob_tail_id=0, no commits of the younger entries.
- query_j_id=2 while rs_ready with rs_rob_id=2 and rs_value=0xAB, entry not yet ready → query_j_ready=1, query_j_value=0xAB in the same cycle.
- Pull rst_in low mid-stream with 5 entries busy → all outputs 0 immediately. After release, the first issue gets id 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: sizing, instruction type codes and the
// entry layout used by the ROB, RS, LSB and decoder.
package rob_pkg;
   localparam int ROB_SIZE  = 8;
   localparam int ROB_WIDTH = 3;

   typedef enum logic [1:0] {
      TYPE_REG  = 2'd0,
      TYPE_BR   = 2'd1,
      TYPE_ST   = 2'd2,
      TYPE_HALT = 2'd3
   } rob_type_e;

   typedef struct packed {
      logic        busy;
      rob_type_e   ty;
      logic [4:0]  rd;
      logic [31:0] pred;
      logic        rdy;
      logic [31:0] val;
   } rob_ent_t;
endpackage

// File: rtl/rob_query.sv
// Combinational operand lookup: a ready entry wins, otherwise the value can be
// picked straight off the RS or LSB broadcast in flight this cycle.
module rob_query #(
   parameter int ROB_SIZE  = rob_pkg::ROB_SIZE,
   parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH
) (
   input  logic [ROB_SIZE-1:0]        ent_rdy,
   input  logic [ROB_SIZE-1:0][31:0]  ent_val,
   input  logic [ROB_WIDTH-1:0]       q_id,
   input  logic                       rs_ready,
   input  logic [ROB_WIDTH-1:0]       rs_rob_id,
   input  logic [31:0]                rs_value,
   input  logic                       lsb_ready,
   input  logic [ROB_WIDTH-1:0]       lsb_rob_id,
   input  logic [31:0]                lsb_value,
   output logic                       q_ready,
   output logic [31:0]                q_value
);
   import rob_pkg::*;

   always_comb begin
      q_ready = 1'b0;
      q_value = 32'd0;
      if (ent_rdy[q_id]) begin
         q_ready = 1'b1;
         q_value = ent_val[q_id];
      end else if (rs_ready && rs_rob_id == q_id) begin
         q_ready = 1'b1;
         q_value = rs_value;
      end else if (lsb_ready && lsb_rob_id == q_id) begin
         q_ready = 1'b1;
         q_value = lsb_value;
      end
   end
endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, out-of-order writeback from RS/LSB,
// in-order commit of register writes, stores, halt and branch resolution.
module rob #(
   parameter int ROB_SIZE  = rob_pkg::ROB_SIZE,
   parameter int ROB_WIDTH = rob_pkg::ROB_WIDTH
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 dec_ready,
   input  logic [1:0]           dec_type,
   input  logic [4:0]           dec_rd,
   input  logic [31:0]          dec_pred_addr,
   input  logic                 dec_val_ready,
   input  logic [31:0]          dec_value,
   output logic                 rob_full,
   output logic [ROB_WIDTH-1:0] rob_tail_id,
   input  logic                 rs_ready,
   input  logic [ROB_WIDTH-1:0] rs_rob_id,
   input  logic [31:0]          rs_value,
   input  logic                 lsb_ready,
   input  logic [ROB_WIDTH-1:0] lsb_rob_id,
   input  logic [31:0]          lsb_value,
   input  logic [ROB_WIDTH-1:0] query_j_id,
   input  logic [ROB_WIDTH-1:0] query_k_id,
   output logic                 query_j_ready,
   output logic                 query_k_ready,
   output logic [31:0]          query_j_value,
   output logic [31:0]          query_k_value,
   output logic                 commit_valid,
   output logic [4:0]           commit_rd,
   output logic [31:0]          commit_value,
   output logic [ROB_WIDTH-1:0] commit_rob_id,
   output logic                 store_commit,
   output logic [ROB_WIDTH-1:0] store_rob_id,
   output logic                 clear,
   output logic [31:0]          redirect_pc,
   output logic                 halt
);
   import rob_pkg::*;

   localparam logic [ROB_WIDTH:0] FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);

   rob_ent_t             ent [ROB_SIZE];
   rob_ent_t             hd;
   logic [ROB_WIDTH-1:0] head, tail;
   logic [ROB_WIDTH:0]   count, cnt_nxt;
   logic                 commit_ok, mispred, issue_ok;

   logic [ROB_SIZE-1:0]           ent_rdy;
   logic [ROB_SIZE-1:0][31:0]     ent_val;
   logic [1:0][ROB_WIDTH-1:0]     q_id;
   logic [1:0]                    q_rdy;
   logic [1:0][31:0]              q_val;

   assign hd          = ent[head];
   assign rob_tail_id = tail;

   // A full buffer may still accept an issue when its head retires this cycle.
   always_comb begin
      commit_ok = hd.busy && hd.rdy && !clear && !halt;
      mispred   = commit_ok && hd.ty == TYPE_BR && hd.val != hd.pred;
      issue_ok  = dec_ready && !clear && (count != FULL_CNT || commit_ok);
      cnt_nxt   = count + (ROB_WIDTH+1)'(issue_ok) - (ROB_WIDTH+1)'(commit_ok);
   end

   always_comb begin
      for (int i = 0; i < ROB_SIZE; i++) begin
         ent_rdy[i] = ent[i].busy && ent[i].rdy;
         ent_val[i] = ent[i].val;
      end
   end

   assign q_id = {query_k_id, query_j_id};

   for (genvar g = 0; g < 2; g++) begin : g_q
      rob_query #(.ROB_SIZE(ROB_SIZE), .ROB_WIDTH(ROB_WIDTH)) u_q (
         .ent_rdy   (ent_rdy),
         .ent_val   (ent_val),
         .q_id      (q_id[g]),
         .rs_ready  (rs_ready),
         .rs_rob_id (rs_rob_id),
         .rs_value  (rs_value),
         .lsb_ready (lsb_ready),
         .lsb_rob_id(lsb_rob_id),
         .lsb_value (lsb_value),
         .q_ready   (q_rdy[g]),
         .q_value   (q_val[g])
      );
   end

   assign query_j_ready = q_rdy[0];
   assign query_j_value = q_val[0];
   assign query_k_ready = q_rdy[1];
   assign query_k_value = q_val[1];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head          <= '0;
         tail          <= '0;
         count         <= '0;
         for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
         rob_full      <= 1'b0;
         commit_valid  <= 1'b0;
         commit_rd     <= '0;
         commit_value  <= '0;
         commit_rob_id <= '0;
         store_commit  <= 1'b0;
         store_rob_id  <= '0;
         clear         <= 1'b0;
         redirect_pc   <= '0;
         halt          <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         store_commit <= 1'b0;
         clear        <= 1'b0;
         if (rdy_in) begin
            // LSB is applied second so it wins a same-id collision.
            for (int i = 0; i < ROB_SIZE; i++) begin
               if (ent[i].busy) begin
                  if (rs_ready && rs_rob_id == ROB_WIDTH'(i)) begin
                     ent[i].rdy <= 1'b1;
                     ent[i].val <= rs_value;
                  end
                  if (lsb_ready && lsb_rob_id == ROB_WIDTH'(i)) begin
                     ent[i].rdy <= 1'b1;
                     ent[i].val <= lsb_value;
                  end
               end
            end
            if (commit_ok) begin
               ent[head].busy <= 1'b0;
               head           <= head + 1'b1;
               case (hd.ty)
                  TYPE_REG: begin
                     commit_valid  <= 1'b1;
                     commit_rd     <= hd.rd;
                     commit_value  <= hd.val;
                     commit_rob_id <= head;
                  end
                  TYPE_ST: begin
                     store_commit <= 1'b1;
                     store_rob_id <= head;
                  end
                  TYPE_HALT: halt <= 1'b1;
                  default: ;
               endcase
            end
            if (issue_ok) begin
               ent[tail] <= '{busy: 1'b1, ty: rob_type_e'(dec_type), rd: dec_rd,
                              pred: dec_pred_addr, rdy: dec_val_ready, val: dec_value};
               tail      <= tail + 1'b1;
            end
            count    <= cnt_nxt;
            rob_full <= (cnt_nxt == FULL_CNT);
            // Mispredict flushes everything, including this cycle's issue.
            if (mispred) begin
               head        <= '0;
               tail        <= '0;
               count       <= '0;
               rob_full    <= 1'b0;
               for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
               clear       <= 1'b1;
               redirect_pc <= hd.val;
            end
         end
      end
   end
endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: issue/writeback/commit ordering, full/wrap,
// mispredict flush, bypass query, stall, store, halt and async reset.
module tb_rob;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        dec_ready, dec_val_ready;
   logic [1:0]  dec_type;
   logic [4:0]  dec_rd;
   logic [31:0] dec_pred_addr, dec_value;
   logic        rob_full;
   logic [2:0]  rob_tail_id;
   logic        rs_ready, lsb_ready;
   logic [2:0]  rs_rob_id, lsb_rob_id;
   logic [31:0] rs_value, lsb_value;
   logic [2:0]  query_j_id, query_k_id;
   logic        query_j_ready, query_k_ready;
   logic [31:0] query_j_value, query_k_value;
   logic        commit_valid, store_commit, clear, halt;
   logic [4:0]  commit_rd;
   logic [31:0] commit_value, redirect_pc;
   logic [2:0]  commit_rob_id, store_rob_id;

   int nvec = 0;
   int nmis = 0;

   rob dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .dec_ready(dec_ready), .dec_type(dec_type), .dec_rd(dec_rd),
      .dec_pred_addr(dec_pred_addr), .dec_val_ready(dec_val_ready), .dec_value(dec_value),
      .rob_full(rob_full), .rob_tail_id(rob_tail_id),
      .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
      .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
      .query_j_id(query_j_id), .query_k_id(query_k_id),
      .query_j_ready(query_j_ready), .query_k_ready(query_k_ready),
      .query_j_value(query_j_value), .query_k_value(query_k_value),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
      .commit_rob_id(commit_rob_id), .store_commit(store_commit), .store_rob_id(store_rob_id),
      .clear(clear), .redirect_pc(redirect_pc), .halt(halt)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      #1;
      rst_in = 1'b1;
   endtask

   task automatic issue(input logic [1:0] ty, input logic [4:0] rd, input logic [31:0] pred,
                        input logic vr, input logic [31:0] val);
      dec_ready = 1'b1; dec_type = ty; dec_rd = rd; dec_pred_addr = pred;
      dec_val_ready = vr; dec_value = val;
      tick();
      dec_ready = 1'b0; dec_val_ready = 1'b0;
   endtask

   task automatic rs_bc(input logic [2:0] id, input logic [31:0] v);
      rs_ready = 1'b1; rs_rob_id = id; rs_value = v;
      tick();
      rs_ready = 1'b0;
   endtask

   task automatic lsb_bc(input logic [2:0] id, input logic [31:0] v);
      lsb_ready = 1'b1; lsb_rob_id = id; lsb_value = v;
      tick();
      lsb_ready = 1'b0;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1;
      dec_ready = 0; dec_type = 0; dec_rd = 0; dec_pred_addr = 0; dec_val_ready = 0; dec_value = 0;
      rs_ready = 0; rs_rob_id = 0; rs_value = 0;
      lsb_ready = 0; lsb_rob_id = 0; lsb_value = 0;
      query_j_id = 0; query_k_id = 0;
      #12;
      chk("rst_full", rob_full, 0);
      chk("rst_tail", rob_tail_id, 0);
      chk("rst_cv", commit_valid, 0);
      chk("rst_clear", clear, 0);
      chk("rst_halt", halt, 0);
      chk("rst_qj", query_j_ready, 0);
      rst_in = 1'b1;
      tick();

      // basic reg-write commit
      issue(2'd0, 5'd5, 0, 1'b0, 0);
      rs_bc(3'd0, 32'h1234);
      tick();
      chk("t1_cv", commit_valid, 1);
      chk("t1_rd", commit_rd, 5);
      chk("t1_val", commit_value, 32'h1234);
      chk("t1_id", commit_rob_id, 0);
      tick();
      chk("t1_cv_pulse", commit_valid, 0);

      // in-order commit despite out-of-order writeback
      do_reset();
      issue(2'd0, 5'd1, 0, 1'b0, 0);
      issue(2'd0, 5'd2, 0, 1'b0, 0);
      lsb_bc(3'd1, 32'd7);
      tick();
      chk("t2_no_early", commit_valid, 0);
      rs_bc(3'd0, 32'd3);
      chk("t2_wait", commit_valid, 0);
      tick();
      chk("t2_c0_v", commit_valid, 1);
      chk("t2_c0_id", commit_rob_id, 0);
      chk("t2_c0_val", commit_value, 3);
      tick();
      chk("t2_c1_v", commit_valid, 1);
      chk("t2_c1_id", commit_rob_id, 1);
      chk("t2_c1_val", commit_value, 7);

      // fill, wrap, commit+issue while full
      do_reset();
      for (int i = 0; i < 8; i++) issue(2'd0, 5'(i + 1), 0, 1'b0, 0);
      chk("t3_full", rob_full, 1);
      chk("t3_tail_wrap", rob_tail_id, 0);
      rs_bc(3'd0, 32'h55);
      issue(2'd0, 5'd9, 0, 1'b0, 0);
      chk("t3_still_full", rob_full, 1);
      chk("t3_tail1", rob_tail_id, 1);
      chk("t3_cv", commit_valid, 1);
      chk("t3_cval", commit_value, 32'h55);
      issue(2'd0, 5'd10, 0, 1'b0, 0);
      chk("t3_ovf_tail", rob_tail_id, 1);
      chk("t3_ovf_full", rob_full, 1);

      // mispredict behind three ready younger entries
      do_reset();
      issue(2'd1, 5'd0, 32'h100, 1'b0, 0);
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 4), 0, 1'b1, 32'(i));
      rs_bc(3'd0, 32'h200);
      tick();
      chk("t4_clear", clear, 1);
      chk("t4_pc", redirect_pc, 32'h200);
      chk("t4_full", rob_full, 0);
      chk("t4_tail", rob_tail_id, 0);
      chk("t4_cv", commit_valid, 0);
      issue(2'd0, 5'd1, 0, 1'b1, 32'h9);
      chk("t4_clear_pulse", clear, 0);
      chk("t4_drop_issue", rob_tail_id, 0);
      chk("t4_cv2", commit_valid, 0);
      tick();
      chk("t4_cv3", commit_valid, 0);

      // bypass query
      do_reset();
      for (int i = 0; i < 3; i++) issue(2'd0, 5'(i + 1), 0, 1'b0, 0);
      query_j_id = 3'd2; query_k_id = 3'd1;
      rs_ready = 1'b1; rs_rob_id = 3'd2; rs_value = 32'hAB;
      lsb_ready = 1'b1; lsb_rob_id = 3'd1; lsb_value = 32'hCD;
      #1;
      chk("t5_j_rdy", query_j_ready, 1);
      chk("t5_j_val", query_j_value, 32'hAB);
      chk("t5_k_rdy", query_k_ready, 1);
      chk("t5_k_val", query_k_value, 32'hCD);
      tick();
      rs_ready = 1'b0; lsb_ready = 1'b0; query_k_id = 3'd0;
      #1;
      chk("t5_j_stored", query_j_value, 32'hAB);
      chk("t5_k_none", query_k_ready, 0);

      // stall and store
      do_reset();
      issue(2'd0, 5'd3, 0, 1'b1, 32'h77);
      rdy_in = 1'b0;
      tick();
      chk("t6_stall", commit_valid, 0);
      rdy_in = 1'b1;
      tick();
      chk("t6_cv", commit_valid, 1);
      chk("t6_val", commit_value, 32'h77);
      issue(2'd2, 5'd0, 0, 1'b1, 0);
      tick();
      chk("t6_st", store_commit, 1);
      chk("t6_st_id", store_rob_id, 1);

      // halt, then async reset with entries busy
      do_reset();
      issue(2'd3, 5'd0, 0, 1'b1, 0);
      tick();
      chk("t7_halt", halt, 1);
      for (int i = 0; i < 5; i++) issue(2'd0, 5'(i + 1), 0, 1'b1, 32'(i));
      chk("t7_blocked", commit_valid, 0);
      chk("t7_tail", rob_tail_id, 6);
      #2;
      rst_in = 1'b0;
      #1;
      chk("t7_rst_halt", halt, 0);
      chk("t7_rst_tail", rob_tail_id, 0);
      chk("t7_rst_full", rob_full, 0);
      rst_in = 1'b1;
      issue(2'd0, 5'd8, 0, 1'b1, 32'h42);
      tick();
      chk("t7_first_id", commit_rob_id, 0);
      chk("t7_first_cv", commit_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
